// File: rtl/ayatsuki_core.sv
// ayatsuki_core: single-cycle RV32I-subset integer core.
// Combinational fetch/decode/execute; PC and register file commit on the rising edge.
module ayatsuki_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    output logic [31:0] inst_addr_o,
    output logic        mem_w_enable_o,
    output logic        mem_r_enable_o,
    output logic        mem_enable_o,
    output logic [31:0] mem_w_addr_o,
    output logic [31:0] mem_r_addr_o,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc_r;
    logic [31:0] regs_r [0:31];

    logic [6:0]  opcode_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic [31:0] ls_addr_s;
    logic [31:0] pc_plus4_s;
    logic [31:0] pc_next_s;
    logic [31:0] wb_data_s;
    logic        wb_en_s;
    logic        load_s;
    logic        store_s;
    logic        taken_s;

    assign opcode_s = inst_i[6:0];
    assign rd_s     = inst_i[11:7];
    assign funct3_s = inst_i[14:12];
    assign rs1_s    = inst_i[19:15];
    assign rs2_s    = inst_i[24:20];
    assign funct7_s = inst_i[31:25];

    assign imm_i_s = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b_s = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u_s = {inst_i[31:12], 12'h000};
    assign imm_j_s = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    // x0 is never written and resets to zero, so it always reads as zero
    assign rs1_val_s  = regs_r[rs1_s];
    assign rs2_val_s  = regs_r[rs2_s];
    assign pc_plus4_s = pc_r + 32'd4;
    assign ls_addr_s  = rs1_val_s + ((opcode_s == OP_STORE) ? imm_s_s : imm_i_s);

    // Decode and execute; anything not recognised falls through as a NOP
    always_comb begin
        pc_next_s = pc_plus4_s;
        wb_en_s   = 1'b0;
        wb_data_s = 32'd0;
        load_s    = 1'b0;
        store_s   = 1'b0;
        taken_s   = 1'b0;
        case (opcode_s)
            OP_LUI: begin
                wb_en_s   = 1'b1;
                wb_data_s = imm_u_s;
            end
            OP_AUIPC: begin
                wb_en_s   = 1'b1;
                wb_data_s = pc_r + imm_u_s;
            end
            OP_JAL: begin
                wb_en_s   = 1'b1;
                wb_data_s = pc_plus4_s;
                pc_next_s = pc_r + imm_j_s;
            end
            OP_JALR: begin
                if (funct3_s == 3'b000) begin
                    wb_en_s   = 1'b1;
                    wb_data_s = pc_plus4_s;
                    pc_next_s = (rs1_val_s + imm_i_s) & 32'hFFFF_FFFE;
                end else begin
                    pc_next_s = pc_plus4_s;
                end
            end
            OP_BRANCH: begin
                case (funct3_s)
                    3'b000:  taken_s = (rs1_val_s == rs2_val_s);
                    3'b001:  taken_s = (rs1_val_s != rs2_val_s);
                    3'b100:  taken_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
                    3'b101:  taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
                    3'b110:  taken_s = (rs1_val_s < rs2_val_s);
                    3'b111:  taken_s = (rs1_val_s >= rs2_val_s);
                    default: taken_s = 1'b0;
                endcase
                if (taken_s) begin
                    pc_next_s = pc_r + imm_b_s;
                end else begin
                    pc_next_s = pc_plus4_s;
                end
            end
            OP_LOAD: begin
                if (funct3_s == 3'b010) begin
                    load_s    = 1'b1;
                    wb_en_s   = 1'b1;
                    wb_data_s = mem_data_i;
                end else begin
                    load_s = 1'b0;
                end
            end
            OP_STORE: begin
                if (funct3_s == 3'b010) begin
                    store_s = 1'b1;
                end else begin
                    store_s = 1'b0;
                end
            end
            OP_IMM: begin
                wb_en_s = 1'b1;
                case (funct3_s)
                    3'b000: wb_data_s = rs1_val_s + imm_i_s;
                    3'b010: wb_data_s = {31'd0, $signed(rs1_val_s) < $signed(imm_i_s)};
                    3'b011: wb_data_s = {31'd0, rs1_val_s < imm_i_s};
                    3'b100: wb_data_s = rs1_val_s ^ imm_i_s;
                    3'b110: wb_data_s = rs1_val_s | imm_i_s;
                    3'b111: wb_data_s = rs1_val_s & imm_i_s;
                    3'b001: begin
                        if (funct7_s == 7'b0000000) begin
                            wb_data_s = rs1_val_s << rs2_s;
                        end else begin
                            wb_en_s = 1'b0;
                        end
                    end
                    3'b101: begin
                        if (funct7_s == 7'b0000000) begin
                            wb_data_s = rs1_val_s >> rs2_s;
                        end else if (funct7_s == 7'b0100000) begin
                            wb_data_s = $unsigned($signed(rs1_val_s) >>> rs2_s);
                        end else begin
                            wb_en_s = 1'b0;
                        end
                    end
                    default: wb_en_s = 1'b0;
                endcase
            end
            OP_REG: begin
                wb_en_s = 1'b1;
                case ({funct7_s, funct3_s})
                    10'b0000000_000: wb_data_s = rs1_val_s + rs2_val_s;
                    10'b0100000_000: wb_data_s = rs1_val_s - rs2_val_s;
                    10'b0000000_001: wb_data_s = rs1_val_s << rs2_val_s[4:0];
                    10'b0000000_010: wb_data_s = {31'd0, $signed(rs1_val_s) < $signed(rs2_val_s)};
                    10'b0000000_011: wb_data_s = {31'd0, rs1_val_s < rs2_val_s};
                    10'b0000000_100: wb_data_s = rs1_val_s ^ rs2_val_s;
                    10'b0000000_101: wb_data_s = rs1_val_s >> rs2_val_s[4:0];
                    10'b0100000_101: wb_data_s = $unsigned($signed(rs1_val_s) >>> rs2_val_s[4:0]);
                    10'b0000000_110: wb_data_s = rs1_val_s | rs2_val_s;
                    10'b0000000_111: wb_data_s = rs1_val_s & rs2_val_s;
                    default:         wb_en_s   = 1'b0;
                endcase
            end
            default: wb_en_s = 1'b0;
        endcase
    end

    // Program counter
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // Register file write-back
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wb_en_s && (rd_s != 5'd0)) begin
            regs_r[rd_s] <= wb_data_s;
        end
    end

    // Memory side is forced quiet while reset is held
    assign inst_addr_o    = pc_r;
    assign mem_w_enable_o = store_s & ~rst_n;
    assign mem_r_enable_o = load_s & ~rst_n;
    assign mem_enable_o   = mem_w_enable_o | mem_r_enable_o;
    assign mem_w_addr_o   = rst_n ? 32'd0 : ls_addr_s;
    assign mem_r_addr_o   = rst_n ? 32'd0 : ls_addr_s;
    assign mem_data_o     = rst_n ? 32'd0 : rs2_val_s;

endmodule

// File: tb/tb_ayatsuki_core.sv
// Directed testbench for ayatsuki_core: big-endian ROM/RAM models and
// hand-computed expectations for PC flow, store data and memory strobes.
module tb_ayatsuki_core;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_o;
    logic        mem_w_enable_o;
    logic        mem_r_enable_o;
    logic        mem_enable_o;
    logic [31:0] mem_w_addr_o;
    logic [31:0] mem_r_addr_o;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;

    logic [31:0] rom [0:63];
    logic [7:0]  ram [0:255];
    logic [7:0]  ra;
    logic [7:0]  wa;
    int          checks = 0;
    int          errors = 0;

    ayatsuki_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_i         (inst_i),
        .inst_addr_o    (inst_addr_o),
        .mem_w_enable_o (mem_w_enable_o),
        .mem_r_enable_o (mem_r_enable_o),
        .mem_enable_o   (mem_enable_o),
        .mem_w_addr_o   (mem_w_addr_o),
        .mem_r_addr_o   (mem_r_addr_o),
        .mem_data_i     (mem_data_i),
        .mem_data_o     (mem_data_o)
    );

    always #5 clk = ~clk;

    assign inst_i     = (inst_addr_o[31:8] == 24'd0) ? rom[inst_addr_o[7:2]] : 32'h0000_0000;
    assign ra         = mem_r_addr_o[7:0];
    assign wa         = mem_w_addr_o[7:0];
    assign mem_data_i = {ram[ra], ram[ra + 8'd1], ram[ra + 8'd2], ram[ra + 8'd3]};

    always @(posedge clk) begin
        if (mem_w_enable_o) begin
            ram[wa]        <= mem_data_o[31:24];
            ram[wa + 8'd1] <= mem_data_o[23:16];
            ram[wa + 8'd2] <= mem_data_o[15:8];
            ram[wa + 8'd3] <= mem_data_o[7:0];
        end
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_REG};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " pc"},     inst_addr_o, 32'h0);
        chk({tag, " we"},     {31'd0, mem_w_enable_o}, 32'd0);
        chk({tag, " re"},     {31'd0, mem_r_enable_o}, 32'd0);
        chk({tag, " en"},     {31'd0, mem_enable_o}, 32'd0);
        chk({tag, " w_addr"}, mem_w_addr_o, 32'd0);
        chk({tag, " r_addr"}, mem_r_addr_o, 32'd0);
        chk({tag, " data"},   mem_data_o, 32'd0);
    endtask

    // check the instruction at the PC, then advance one clock
    task automatic step(input logic [31:0] pc, input logic we, input logic re);
        chk($sformatf("pc@%h", pc), inst_addr_o, pc);
        chk($sformatf("we@%h", pc), {31'd0, mem_w_enable_o}, {31'd0, we});
        chk($sformatf("re@%h", pc), {31'd0, mem_r_enable_o}, {31'd0, re});
        chk($sformatf("en@%h", pc), {31'd0, mem_enable_o}, {31'd0, we | re});
        @(posedge clk);
        #2;
    endtask

    task automatic st_step(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data);
        chk($sformatf("w_addr@%h", pc), mem_w_addr_o, addr);
        chk($sformatf("w_data@%h", pc), mem_data_o, data);
        step(pc, 1'b1, 1'b0);
    endtask

    task automatic rom_fill(input logic [31:0] word);
        for (int i = 0; i < 64; i++) begin
            rom[i] = word;
        end
    endtask

    initial begin
        // Phase 0: reset gating and sequential fetch of NOPs
        rst_n = 1'b1;
        rom_fill(NOP);
        rom[0] = enc_s(32'd12, 5'd0, 5'd0);
        #2;
        chk_quiet("reset");
        @(posedge clk);
        #2;
        chk_quiet("reset held");
        rst_n = 1'b0;
        #1;
        st_step(32'h00, 32'd12, 32'd0);
        step(32'h04, 1'b0, 1'b0);
        step(32'h08, 1'b0, 1'b0);
        step(32'h0C, 1'b0, 1'b0);

        // Phase A: arithmetic, observed through stores
        rst_n = 1'b1;
        #1;
        chk_quiet("async reset A");
        rom_fill(NOP);
        rom[0]  = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OP_IMM);
        rom[1]  = enc_i(32'hFFFF_FFFD, 5'd0, 3'b000, 5'd2, OP_IMM);
        rom[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        rom[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4);
        rom[4]  = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5);
        rom[5]  = enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd6);
        rom[6]  = enc_i(32'h0000_0401, 5'd2, 3'b101, 5'd7, OP_IMM);
        rom[7]  = enc_i(32'd28, 5'd2, 3'b101, 5'd8, OP_IMM);
        rom[8]  = enc_i(32'hFFFF_FFFF, 5'd1, 3'b100, 5'd9, OP_IMM);
        rom[9]  = enc_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd10);
        rom[10] = {20'h00001, 5'd11, OP_AUIPC};
        rom[11] = enc_s(32'd0,  5'd3,  5'd0);
        rom[12] = enc_s(32'd4,  5'd4,  5'd0);
        rom[13] = enc_s(32'd8,  5'd5,  5'd0);
        rom[14] = enc_s(32'd12, 5'd6,  5'd0);
        rom[15] = enc_s(32'd16, 5'd7,  5'd0);
        rom[16] = enc_s(32'd20, 5'd8,  5'd0);
        rom[17] = enc_s(32'd24, 5'd9,  5'd0);
        rom[18] = enc_s(32'd28, 5'd10, 5'd2);
        rom[19] = enc_s(32'd32, 5'd11, 5'd0);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 11; k++) begin
            step(32'(k * 4), 1'b0, 1'b0);
        end
        st_step(32'h2C, 32'd0,  32'h0000_0002);
        st_step(32'h30, 32'd4,  32'h0000_0008);
        st_step(32'h34, 32'd8,  32'h0000_0001);
        st_step(32'h38, 32'd12, 32'h0000_0000);
        st_step(32'h3C, 32'd16, 32'hFFFF_FFFE);
        st_step(32'h40, 32'd20, 32'h0000_000F);
        st_step(32'h44, 32'd24, 32'hFFFF_FFFA);
        st_step(32'h48, 32'd25, 32'h0000_00A0);
        st_step(32'h4C, 32'd32, 32'h0000_1028);

        // Phase B: load/store round trip, branches and jumps
        rst_n = 1'b1;
        #1;
        chk_quiet("async reset B");
        rom_fill(32'h0000_0000);
        rom[0]  = {20'h12345, 5'd1, OP_LUI};
        rom[1]  = enc_i(32'h678, 5'd1, 3'b000, 5'd1, OP_IMM);
        rom[2]  = enc_s(32'd16, 5'd1, 5'd0);
        rom[3]  = enc_i(32'd16, 5'd0, 3'b010, 5'd7, OP_LOAD);
        rom[4]  = enc_r(7'h00, 5'd7, 5'd7, 3'b000, 5'd0);
        rom[5]  = enc_s(32'd20, 5'd7, 5'd0);
        rom[6]  = enc_s(32'd24, 5'd0, 5'd0);
        rom[7]  = NOP;
        rom[8]  = enc_b(32'd8, 5'd1, 5'd1, 3'b000);
        rom[9]  = enc_s(32'd0, 5'd1, 5'd0);
        rom[10] = enc_b(32'd8, 5'd1, 5'd1, 3'b001);
        rom[11] = enc_j(32'd12, 5'd1);
        rom[12] = enc_s(32'd28, 5'd5, 5'd0);
        rom[13] = enc_j(32'd12, 5'd0);
        rom[14] = enc_i(32'd1, 5'd1, 3'b000, 5'd5, OP_JALR);
        rom[15] = NOP;
        rom[16] = enc_s(32'd32, 5'd1, 5'd0);
        rom[17] = enc_i(32'hFFFF_FFFF, 5'd0, 3'b000, 5'd2, OP_IMM);
        rom[18] = enc_b(32'd8, 5'd0, 5'd2, 3'b100);
        rom[19] = enc_s(32'd0, 5'd1, 5'd0);
        rom[20] = enc_b(32'd8, 5'd0, 5'd2, 3'b110);
        rom[21] = enc_b(32'd8, 5'd2, 5'd0, 3'b101);
        rom[22] = enc_s(32'd0, 5'd1, 5'd0);
        rst_n = 1'b0;
        #1;
        step(32'h00, 1'b0, 1'b0);
        step(32'h04, 1'b0, 1'b0);
        st_step(32'h08, 32'd16, 32'h1234_5678);
        chk("ram[16..19]", {ram[16], ram[17], ram[18], ram[19]}, 32'h1234_5678);
        chk("ram[16]", {24'd0, ram[16]}, 32'h0000_0012);
        chk("lw r_addr", mem_r_addr_o, 32'd16);
        step(32'h0C, 1'b0, 1'b1);
        step(32'h10, 1'b0, 1'b0);
        st_step(32'h14, 32'd20, 32'h1234_5678);
        st_step(32'h18, 32'd24, 32'h0000_0000);
        step(32'h1C, 1'b0, 1'b0);
        step(32'h20, 1'b0, 1'b0);
        step(32'h28, 1'b0, 1'b0);
        step(32'h2C, 1'b0, 1'b0);
        step(32'h38, 1'b0, 1'b0);
        st_step(32'h30, 32'd28, 32'h0000_003C);
        step(32'h34, 1'b0, 1'b0);
        st_step(32'h40, 32'd32, 32'h0000_0030);
        step(32'h44, 1'b0, 1'b0);
        step(32'h48, 1'b0, 1'b0);
        step(32'h50, 1'b0, 1'b0);
        step(32'h54, 1'b0, 1'b0);
        step(32'h5C, 1'b0, 1'b0);
        step(32'h60, 1'b0, 1'b0);
        chk("pc before mid reset", inst_addr_o, 32'h64);

        // Phase C: mid-program reset clears registers; zero words act as NOPs
        rst_n = 1'b1;
        #1;
        chk_quiet("async reset mid");
        rom_fill(32'h0000_0000);
        rom[0] = enc_s(32'd36, 5'd7, 5'd0);
        rom[1] = enc_s(32'd40, 5'd1, 5'd0);
        @(posedge clk);
        #2;
        chk_quiet("reset held C");
        rst_n = 1'b0;
        #1;
        st_step(32'h00, 32'd36, 32'h0000_0000);
        st_step(32'h04, 32'd40, 32'h0000_0000);
        step(32'h08, 1'b0, 1'b0);
        step(32'h0C, 1'b0, 1'b0);
        step(32'h10, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
